crf_loader: RTL and testbench
=============================

# crf_loader

Sequencer that fills the per-PE constant register file (CRF) from a 32-bit configuration stream. It accepts a header word and then pairs of 32-bit words over a valid/ready handshake, assembles each pair into one 64-bit constant, and issues single-cycle write strobes on the CRF write port. It sits between the PE configuration bus and the CRF write port: Write_En, Write_Addr and In_Const connect directly to the CRF. The high word goes to bits 63:32, which the CRF reads at even half-word addresses.

## Interface
- WRITE_AWIDTH, 4: CRF entry address width.
- WRITE_DWIDTH, 64: CRF entry width; must equal 2*IN_DWIDTH.
- IN_DWIDTH, 32: configuration stream word width.
- NUM_REGS, 16: number of CRF entries.

- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- Clear  input  1  synchronous abort; returns to IDLE.
- In_Valid  input  1  stream word valid.
- In_Data  input  IN_DWIDTH  stream word.
- In_Ready  output  1  loader accepts In_Data this cycle.
- Write_En  output  1  CRF write strobe, one cycle per entry.
- Write_Addr  output  WRITE_AWIDTH  CRF entry address.
- In_Const  output  WRITE_DWIDTH  CRF write data.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when a load completes.
- Error  output  1  one-cycle pulse when a header is rejected.

## Operation
- States: IDLE, HDR, HI, LO, WR, DONE, ERR.
- A word is transferred on an edge where In_Valid and In_Ready are both 1.
- In_Ready = 1 only in HDR, HI and LO. In_Ready does not depend on In_Valid.
- IDLE: on Start = 1, go to HDR. Otherwise stay in IDLE.
- HDR: on transfer, decode the header word.
  - In_Data[3:0] is the base address. In_Data[8:4] is the entry count. Bits 31:9 are ignored.
  - Valid header: count is 1..NUM_REGS and base + count <= NUM_REGS (6-bit compare). Latch addr = base and remaining = count, then go to HI.
  - Any other header goes to ERR.
- HI: on transfer, latch the word into hi_reg and go to LO.
- LO: on transfer, register In_Const = {hi_reg, In_Data} and Write_Addr = addr, then go to WR.
- WR: Write_En = 1 for exactly this one cycle. Then increment addr and decrement remaining.
  - If the decremented remaining is 0, go to DONE. Otherwise go to HI.
- DONE: Done = 1 for one cycle, then go to IDLE.
- ERR: Error = 1 for one cycle, then go to IDLE. No write is issued.
- Write_En, Write_Addr and In_Const are registered outputs.
- In_Const and Write_Addr hold their last values outside WR. Only Write_En qualifies them.
- addr never wraps, because the header check guarantees addr + remaining <= NUM_REGS.
- Clear = 1 in any state: next state is IDLE. No further Write_En, Done or Error is produced. Words already written stay in the CRF.
- Priority: Reset > Clear > Start / transfers.
- Start while Busy is ignored.
- Start and Clear in the same cycle: Clear wins and the loader stays IDLE.

## Timing
- Reset values: In_Ready = 0, Write_En = 0, Write_Addr = 0, In_Const = 0, Busy = 0, Done = 0, Error = 0. State is IDLE, internal counters and hi_reg are 0.
- Reset asserted mid-load: outputs clear immediately (asynchronous); the partial entry is never written.
- Start at edge t: HDR, with In_Ready = 1, during cycle t+1.
- LO word transferred at edge k: Write_En = 1 during cycle k+1.
- Best case, with In_Valid held high: 3 cycles per entry (HI, LO, WR).
- Last WR cycle at c: Done = 1 during cycle c+1, IDLE at c+2.
- Invalid header transferred at edge h: Error = 1 during cycle h+1, IDLE at h+2.
- In_Valid low in HDR, HI or LO: the loader stalls indefinitely with no timeout; Busy stays 1.

## Test plan
- Reset check: assert Reset mid-LO -> all outputs 0 in the same cycle; no Write_En after release; Busy = 0.
- Single-entry load: Start, header 0x00000013 (base 3, count 1), words 0xAAAA5555 then 0x12345678 -> one Write_En cycle with Write_Addr = 3 and In_Const = 0xAAAA5555_12345678; Done one cycle later.
- Full-file load: header 0x00000100 (base 0, count 16), 32 words with In_Valid held high -> 16 Write_En pulses at addresses 0..15, spaced exactly 3 cycles apart; a single Done pulse.
- Rejected headers: header 0x0000002F (base 15, count 2) -> Error pulse, no Write_En, IDLE. Header 0x00000000 (count 0) -> Error pulse. Header 0x00000110 (count 17) -> Error pulse.
- Stalls and abort: load count 3 with In_Valid toggling randomly -> writes at base..base+2 carry the correct data. Separately, assert Clear after the first LO transfer -> the Write_En already pending completes, then IDLE; no Done.
- Ignored Start: pulse Start while Busy, and pulse Start together with Clear -> no second header phase; the loader reaches IDLE.

Source files
------------

// File: rtl/crf_loader.sv
// crf_loader: assembles pairs of 32-bit config words into 64-bit CRF entries.
module crf_loader #(
  parameter int WRITE_AWIDTH = 4,
  parameter int WRITE_DWIDTH = 64,
  parameter int IN_DWIDTH    = 32,
  parameter int NUM_REGS     = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Clear,
  input  logic                    In_Valid,
  input  logic [IN_DWIDTH-1:0]    In_Data,
  output logic                    In_Ready,
  output logic                    Write_En,
  output logic [WRITE_AWIDTH-1:0] Write_Addr,
  output logic [WRITE_DWIDTH-1:0] In_Const,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);
  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WR, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [IN_DWIDTH-1:0] hi_reg;
  logic [WRITE_AWIDTH-1:0] addr;
  logic [4:0] remaining;
  logic [5:0] hdr_end;
  logic hdr_ok, xfer;
  assign xfer     = In_Valid && In_Ready;
  assign hdr_end  = {2'b0, In_Data[3:0]} + {1'b0, In_Data[8:4]};
  assign hdr_ok   = In_Data[8:4] != 5'd0 && In_Data[8:4] <= 5'(NUM_REGS) && hdr_end <= 6'(NUM_REGS);
  assign In_Ready = state == HDR || state == HI || state == LO;
  assign Busy     = state != IDLE;
  assign Done     = state == DONE;
  assign Error    = state == ERR;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Start ? HDR : IDLE;
      HDR:     state_nx = xfer ? (hdr_ok ? HI : ERR) : HDR;
      HI:      state_nx = xfer ? LO : HI;
      LO:      state_nx = xfer ? WR : LO;
      WR:      state_nx = remaining == 5'd1 ? DONE : HI;
      default: state_nx = IDLE;
    endcase
    if (Clear) state_nx = IDLE;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      hi_reg     <= '0;
      addr       <= '0;
      remaining  <= '0;
      Write_En   <= 1'b0;
      Write_Addr <= '0;
      In_Const   <= '0;
    end else begin
      state    <= state_nx;
      Write_En <= state == LO && state_nx == WR;
      if (state == HDR && state_nx == HI) begin
        addr      <= In_Data[WRITE_AWIDTH-1:0];
        remaining <= In_Data[8:4];
      end
      if (state == HI && state_nx == LO) hi_reg <= In_Data;
      if (state == LO && state_nx == WR) begin
        In_Const   <= {hi_reg, In_Data};
        Write_Addr <= addr;
      end
      if (state == WR) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_crf_loader.sv
// tb_crf_loader: randomized loads checked by a scoreboard fed from a header-level model.
module tb_crf_loader;
  logic Clk = 0, Reset = 1, Start = 0, Clear = 0, In_Valid = 0;
  logic [31:0] In_Data = '0;
  logic In_Ready, Write_En, Busy, Done, Error;
  logic [3:0] Write_Addr;
  logic [63:0] In_Const;

  crf_loader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Clear(Clear), .In_Valid(In_Valid),
    .In_Data(In_Data), .In_Ready(In_Ready), .Write_En(Write_En), .Write_Addr(Write_Addr),
    .In_Const(In_Const), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {int kind; int addr; logic [63:0] data;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0, cyc = 0, last_wr = -100;
  bit chk_sp = 0;

  task automatic check(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Monitor: every Write_En / Done / Error must match the next expected event.
  always @(negedge Clk) begin
    if (!Reset && (Write_En || Done || Error)) begin
      automatic int k = Write_En ? 0 : (Done ? 1 : 2);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
        automatic ev_t e = q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (k == 0) begin
          check("write_addr", 64'(Write_Addr), 64'(e.addr));
          check("write_data", In_Const, e.data);
        end
      end
      if (Write_En) begin
        if (chk_sp && last_wr >= 0) check("write_spacing", 64'(cyc - last_wr), 64'd3);
        last_wr = cyc;
      end
      if (Done) check("done_after_wr", 64'(cyc - last_wr), 64'd1);
    end
  end

  task automatic send(logic [31:0] w, int gap);
    int n = 0;
    repeat (gap) begin
      In_Valid = 0;
      @(negedge Clk);
    end
    In_Valid = 1;
    In_Data  = w;
    while (!In_Ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!In_Ready) check("ready_timeout", 0, 1);
    @(negedge Clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("reach_idle", 64'(Busy), 0);
    @(negedge Clk);
  endtask

  task automatic start_hdr();
    Start = 1;
    @(negedge Clk);
    Start = 0;
    check("hdr_ready", 64'(In_Ready), 1);
  endtask

  // Model: header decides whether entries base..base+count-1 get written, then Done; else Error.
  task automatic load(int base, int count, int gap_max, bit start_busy);
    logic [31:0] w[$];
    int h = (count << 4) | base;
    bit ok = count >= 1 && count <= 16 && base + count <= 16;
    for (int i = 0; i < 2 * count; i++) w.push_back($urandom);
    if (ok) begin
      for (int i = 0; i < count; i++) q.push_back('{0, base + i, {w[2*i], w[2*i+1]}});
      q.push_back('{1, 0, 64'd0});
    end else q.push_back('{2, 0, 64'd0});
    start_hdr();
    send(32'(h) | ($urandom << 9), $urandom_range(0, gap_max));
    if (ok)
      for (int i = 0; i < 2 * count; i++) begin
        Start = start_busy && i == 0;
        send(w[i], $urandom_range(0, gap_max));
        Start = 0;
      end
    In_Valid = 0;
    wait_idle();
  endtask

  initial begin
    #1;
    check("rst_ready", 64'(In_Ready), 0);
    check("rst_busy", 64'(Busy), 0);
    check("rst_we", 64'(Write_En), 0);
    check("rst_addr", 64'(Write_Addr), 0);
    check("rst_const", In_Const, 0);
    check("rst_done_err", 64'({Done, Error}), 0);
    @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    // single entry, fixed data
    q.push_back('{0, 3, 64'hAAAA5555_12345678});
    q.push_back('{1, 0, 64'd0});
    start_hdr();
    send(32'h13, 0);
    send(32'hAAAA5555, 0);
    send(32'h12345678, 0);
    In_Valid = 0;
    wait_idle();
    // full file, back to back
    chk_sp = 1;
    last_wr = -100;
    load(0, 16, 0, 0);
    chk_sp = 0;
    // rejected headers: base15/count2, count0, count17
    load(15, 2, 0, 0);
    load(0, 0, 0, 0);
    load(0, 17, 0, 0);
    // stalls, Start while busy, random loads
    load(4, 3, 3, 1);
    for (int i = 0; i < 8; i++) begin
      automatic int b = $urandom_range(0, 15);
      load(b, $urandom_range(1, 16 - b), 2, 0);
    end
    load($urandom_range(0, 15), $urandom_range(1, 20), 1, 0);
    // Clear during the first WR: that write completes, no Done
    q.push_back('{0, 5, 64'h0});
    start_hdr();
    send(32'h35, 0);
    send(32'hDEADBEEF, 0);
    q[q.size()-1].data = 64'hDEADBEEF_CAFEF00D;
    send(32'hCAFEF00D, 0);
    In_Valid = 0;
    Clear = 1;
    @(negedge Clk);
    Clear = 0;
    check("clear_idle", 64'(Busy), 0);
    repeat (4) @(negedge Clk);
    // Start together with Clear stays idle
    Start = 1;
    Clear = 1;
    @(negedge Clk);
    Start = 0;
    Clear = 0;
    check("start_clear_busy", 64'(Busy), 0);
    check("start_clear_ready", 64'(In_Ready), 0);
    // Reset while in LO
    start_hdr();
    send(32'h22, 0);
    send(32'h11111111, 0);
    In_Valid = 0;
    check("in_lo_ready", 64'(In_Ready), 1);
    #2 Reset = 1;
    #1;
    check("mid_rst_outs", 64'({In_Ready, Write_En, Busy, Done, Error}), 0);
    check("mid_rst_addr", 64'(Write_Addr), 0);
    check("mid_rst_const", In_Const, 0);
    @(negedge Clk);
    Reset = 0;
    In_Valid = 1;
    repeat (5) @(negedge Clk);
    In_Valid = 0;
    check("post_rst_busy", 64'(Busy), 0);
    check("queue_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
